// File: rtl/layernorm_sched_pkg.sv
// Shared encodings and width helpers for the LayerNorm row scheduler.
package layernorm_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } sched_state_e;

  typedef enum logic [1:0] {
    ENG_FREE    = 2'd0,
    ENG_RUNNING = 2'd1,
    ENG_PENDING = 2'd2
  } eng_state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned row_w(input int unsigned rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned rows);
    return $clog2(rows + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Rotating-priority arbiter: one-hot grant, pointer moves just past each winner.
module rr_arbiter_n
  import layernorm_sched_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = idx_w(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant_c,
  output logic [IDX_W-1:0] grant_idx_c
);

  logic [IDX_W-1:0] ptr_q, ptr_d, cand;
  logic             found;

  // Scan requesters starting at the pointer; first hit wins.
  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    found       = 1'b0;
    cand        = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IDX_W'((32'(ptr_q) + i) % N);
      if (!found && req[cand]) begin
        found          = 1'b1;
        grant_c[cand]  = 1'b1;
        grant_idx_c    = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found) ptr_d = IDX_W'((32'(grant_idx_c) + 32'd1) % N);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/layernorm_row_scheduler.sv
// Time-multiplexes LayerNorm rows over a small engine pool and serialises
// their writebacks through one result port.
module layernorm_row_scheduler
  import layernorm_sched_pkg::*;
#(
  parameter int unsigned SENTENCE_NUM = 128,
  parameter int unsigned ENGINE_NUM   = 4,
  parameter int unsigned ROW_W        = row_w(SENTENCE_NUM),
  parameter int unsigned CNT_W        = cnt_w(SENTENCE_NUM)
) (
  input  logic                        clk_p,
  input  logic                        rst_n,
  input  logic                        start_n,
  input  logic [CNT_W-1:0]            row_count,
  input  logic [ENGINE_NUM-1:0]       eng_done_n,
  output logic [ENGINE_NUM-1:0]       eng_start_n,
  output logic [ENGINE_NUM*ROW_W-1:0] eng_row_idx,
  output logic                        wb_valid_n,
  output logic [ROW_W-1:0]            wb_eng_sel,
  output logic [ROW_W-1:0]            wb_row_idx,
  output logic                        busy,
  output logic                        done_n,
  output logic                        err_spur
);

  localparam int unsigned      IDX_W    = idx_w(ENGINE_NUM);
  localparam logic [CNT_W-1:0] MAX_ROWS = CNT_W'(SENTENCE_NUM);

  sched_state_e                       state_q, state_d;
  eng_state_e                         eng_state_q [ENGINE_NUM];
  eng_state_e                         eng_state_d [ENGINE_NUM];
  logic [CNT_W-1:0]                   n_q, n_d, next_row_q, next_row_d;
  logic [ENGINE_NUM-1:0][ROW_W-1:0]   row_idx_q, row_idx_d;
  logic [ENGINE_NUM-1:0]              eng_start_n_q, eng_start_n_d;
  logic                               wb_valid_n_q, wb_valid_n_d;
  logic [ROW_W-1:0]                   wb_eng_sel_q, wb_eng_sel_d;
  logic [ROW_W-1:0]                   wb_row_idx_q, wb_row_idx_d;
  logic                               busy_q, busy_d, done_n_q, done_n_d;
  logic                               err_spur_q, err_spur_d;

  logic [CNT_W-1:0]      n_clamp, disp_n, disp_row;
  logic                  disp_ok, free_found, all_free;
  logic [IDX_W-1:0]      free_idx, gidx;
  logic [ENGINE_NUM-1:0] pend_req, grant;

  assign n_clamp = (row_count > MAX_ROWS) ? MAX_ROWS : row_count;

  // Lowest-index free engine, plus pending-request vector for the arbiter.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    all_free   = 1'b1;
    pend_req   = '0;
    for (int k = int'(ENGINE_NUM) - 1; k >= 0; k--) begin
      if (eng_state_q[k] == ENG_FREE) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(k);
      end else begin
        all_free = 1'b0;
      end
      pend_req[k] = (eng_state_q[k] == ENG_PENDING);
    end
  end

  rr_arbiter_n #(
    .N     (ENGINE_NUM),
    .IDX_W (IDX_W)
  ) u_wb_arb (
    .clk         (clk_p),
    .rst_n       (rst_n),
    .req         (pend_req),
    .grant_c     (grant),
    .grant_idx_c (gidx)
  );

  always_comb begin
    state_d       = state_q;
    eng_state_d   = eng_state_q;
    n_d           = n_q;
    next_row_d    = next_row_q;
    row_idx_d     = row_idx_q;
    eng_start_n_d = '1;
    wb_valid_n_d  = 1'b1;
    wb_eng_sel_d  = wb_eng_sel_q;
    wb_row_idx_d  = wb_row_idx_q;
    busy_d        = busy_q;
    done_n_d      = 1'b1;
    err_spur_d    = err_spur_q;
    disp_ok       = 1'b0;
    disp_n        = n_q;
    disp_row      = next_row_q;

    // On the accepting edge dispatch already uses the freshly latched count.
    case (state_q)
      ST_IDLE: begin
        if (!start_n) begin
          n_d        = n_clamp;
          next_row_d = '0;
          disp_n     = n_clamp;
          disp_row   = '0;
          if (n_clamp == '0) begin
            state_d  = ST_FIN;
            done_n_d = 1'b0;
            busy_d   = 1'b0;
          end else begin
            state_d  = ST_RUN;
            busy_d   = 1'b1;
            disp_ok  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        disp_ok = 1'b1;
        if ((next_row_q == n_q) && all_free) begin
          state_d  = ST_FIN;
          done_n_d = 1'b0;
          busy_d   = 1'b0;
          disp_ok  = 1'b0;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A completion counts only from a running engine past its start cycle.
    for (int k = 0; k < int'(ENGINE_NUM); k++) begin
      if (!eng_done_n[k]) begin
        if ((eng_state_q[k] == ENG_RUNNING) && eng_start_n_q[k]) eng_state_d[k] = ENG_PENDING;
        else                                                      err_spur_d     = 1'b1;
      end
    end

    if (|grant) begin
      wb_valid_n_d      = 1'b0;
      wb_eng_sel_d      = ROW_W'(gidx);
      wb_row_idx_d      = row_idx_q[gidx];
      eng_state_d[gidx] = ENG_FREE;
    end

    if (disp_ok && (disp_row < disp_n) && free_found) begin
      eng_start_n_d[free_idx] = 1'b0;
      row_idx_d[free_idx]     = ROW_W'(disp_row);
      eng_state_d[free_idx]   = ENG_RUNNING;
      next_row_d              = disp_row + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_p) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      for (int k = 0; k < int'(ENGINE_NUM); k++) eng_state_q[k] <= ENG_FREE;
      n_q           <= '0;
      next_row_q    <= '0;
      row_idx_q     <= '0;
      eng_start_n_q <= '1;
      wb_valid_n_q  <= 1'b1;
      wb_eng_sel_q  <= '0;
      wb_row_idx_q  <= '0;
      busy_q        <= 1'b0;
      done_n_q      <= 1'b1;
      err_spur_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      eng_state_q   <= eng_state_d;
      n_q           <= n_d;
      next_row_q    <= next_row_d;
      row_idx_q     <= row_idx_d;
      eng_start_n_q <= eng_start_n_d;
      wb_valid_n_q  <= wb_valid_n_d;
      wb_eng_sel_q  <= wb_eng_sel_d;
      wb_row_idx_q  <= wb_row_idx_d;
      busy_q        <= busy_d;
      done_n_q      <= done_n_d;
      err_spur_q    <= err_spur_d;
    end
  end

  assign eng_start_n = eng_start_n_q;
  assign eng_row_idx = row_idx_q;
  assign wb_valid_n  = wb_valid_n_q;
  assign wb_eng_sel  = wb_eng_sel_q;
  assign wb_row_idx  = wb_row_idx_q;
  assign busy        = busy_q;
  assign done_n      = done_n_q;
  assign err_spur    = err_spur_q;

endmodule
